id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 126 ++++++++++++
 tb/tb_id_ex_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall hold, flush/invalid bubble insertion and optional bubble counter
//
// Optional feature macro: ID_EX_BUBBLE_CNT_EN (adds the 16-bit saturating bubble_cnt_out port)
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset; clears every output
//   WB_in/MEM_in   decoder control bundles {RegWrite,MemtoReg} / {MemRead,MemWrite}
//   EX_in          decoder EX bundle {RegDst, ALUOp[1:0], ALUSrc}
//   valid_in       ID slot holds a real instruction
//   stall_in       hold every output this cycle
//   flush_in       insert a bubble this cycle (wins over stall_in)
//   *_in data      PC+4, register read data, immediate, register specifiers
//   *_out          registered copies of the above; valid_out marks a real instruction
//   bubble_cnt_out saturating count of inserted bubbles (macro builds only)
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        WB_in,
    input  logic [1:0]        MEM_in,
    input  logic [3:0]        EX_in,
    input  logic              valid_in,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic [DATA_W-1:0] pc_plus4_in,
    input  logic [DATA_W-1:0] rd_data1_in,
    input  logic [DATA_W-1:0] rd_data2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    output logic [1:0]        WB_out,
    output logic [1:0]        MEM_out,
    output logic [3:0]        EX_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc_plus4_out,
    output logic [DATA_W-1:0] rd_data1_out,
    output logic [DATA_W-1:0] rd_data2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [15:0]       bubble_cnt_out
`endif
);

    logic              w_load;
    logic              w_bubble;
    logic [1:0]        r_wb;
    logic [1:0]        r_mem;
    logic [3:0]        r_ex;
    logic              r_valid;
    logic [DATA_W-1:0] r_pc_plus4;
    logic [DATA_W-1:0] r_rd_data1;
    logic [DATA_W-1:0] r_rd_data2;
    logic [DATA_W-1:0] r_imm;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;

    // Flush overrides stall, so the register loads unless a stall is alone.
    // A bubble is a flush or an unstalled empty ID slot; its control is zeroed
    // so no RegWrite/MemRead/MemWrite can leak downstream.
    assign w_load   = flush_in | ~stall_in;
    assign w_bubble = flush_in | (~stall_in & ~valid_in);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wb       <= '0;
            r_mem      <= '0;
            r_ex       <= '0;
            r_valid    <= 1'b0;
            r_pc_plus4 <= '0;
            r_rd_data1 <= '0;
            r_rd_data2 <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
        end else if (w_load) begin
            r_wb       <= w_bubble ? 2'b00 : WB_in;
            r_mem      <= w_bubble ? 2'b00 : MEM_in;
            r_ex       <= w_bubble ? 4'b0000 : EX_in;
            r_valid    <= ~w_bubble;
            r_pc_plus4 <= pc_plus4_in;
            r_rd_data1 <= rd_data1_in;
            r_rd_data2 <= rd_data2_in;
            r_imm      <= imm_in;
            r_rs       <= rs_in;
            r_rt       <= rt_in;
            r_rd       <= rd_in;
        end
    end

    assign WB_out       = r_wb;
    assign MEM_out      = r_mem;
    assign EX_out       = r_ex;
    assign valid_out    = r_valid;
    assign pc_plus4_out = r_pc_plus4;
    assign rd_data1_out = r_rd_data1;
    assign rd_data2_out = r_rd_data2;
    assign imm_out      = r_imm;
    assign rs_out       = r_rs;
    assign rt_out       = r_rt;
    assign rd_out       = r_rd;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;

    // Counts bubbles actually written into EX; saturates instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_bubble_cnt <= '0;
        else if (w_load && w_bubble && r_bubble_cnt != 16'hFFFF)
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end

    assign bubble_cnt_out = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: random and directed self-checking bench for id_ex_reg against a behavioural model
module tb_id_ex_reg;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  WB_in = '0, MEM_in = '0;
    logic [3:0]  EX_in = '0;
    logic        valid_in = 1'b0, stall_in = 1'b0, flush_in = 1'b0;
    logic [31:0] pc_plus4_in = '0, rd_data1_in = '0, rd_data2_in = '0, imm_in = '0;
    logic [4:0]  rs_in = '0, rt_in = '0, rd_in = '0;
    logic [1:0]  WB_out, MEM_out;
    logic [3:0]  EX_out;
    logic        valid_out;
    logic [31:0] pc_plus4_out, rd_data1_out, rd_data2_out, imm_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic [15:0] cnt_act;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    id_ex_reg #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .WB_in(WB_in), .MEM_in(MEM_in), .EX_in(EX_in),
        .valid_in(valid_in), .stall_in(stall_in), .flush_in(flush_in),
        .pc_plus4_in(pc_plus4_in), .rd_data1_in(rd_data1_in),
        .rd_data2_in(rd_data2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .WB_out(WB_out), .MEM_out(MEM_out), .EX_out(EX_out),
        .valid_out(valid_out), .pc_plus4_out(pc_plus4_out),
        .rd_data1_out(rd_data1_out), .rd_data2_out(rd_data2_out),
        .imm_out(imm_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .bubble_cnt_out(cnt_act)
`endif
    );

`ifndef ID_EX_BUBBLE_CNT_EN
    assign cnt_act = '0;
`endif

    always #5 clk = ~clk;

    // Behavioural model: the EX slot as a record of fields plus a bubble tally.
    logic [1:0]  m_wb, m_mem;
    logic [3:0]  m_ex;
    logic        m_valid;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    int          m_bubbles;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {m_wb, m_mem, m_ex, m_valid} = '0;
            {m_pc, m_d1, m_d2, m_imm, m_rs, m_rt, m_rd} = '0;
            m_bubbles = 0;
        end else if (stall_in && !flush_in) begin
            // held
        end else begin
            m_pc = pc_plus4_in; m_d1 = rd_data1_in; m_d2 = rd_data2_in; m_imm = imm_in;
            m_rs = rs_in; m_rt = rt_in; m_rd = rd_in;
            if (flush_in || !valid_in) begin
                m_wb = 0; m_mem = 0; m_ex = 0; m_valid = 0;
                m_bubbles = m_bubbles + 1;
            end else begin
                m_wb = WB_in; m_mem = MEM_in; m_ex = EX_in; m_valid = 1;
            end
        end
    end

    function automatic logic [151:0] dut_vec();
        return {WB_out, MEM_out, EX_out, valid_out, pc_plus4_out, rd_data1_out,
                rd_data2_out, imm_out, rs_out, rt_out, rd_out};
    endfunction

    function automatic logic [151:0] mdl_vec();
        return {m_wb, m_mem, m_ex, m_valid, m_pc, m_d1, m_d2, m_imm, m_rs, m_rt, m_rd};
    endfunction

    task automatic chk(input string n, input logic [159:0] a, input logic [159:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", n, a, e);
        end
    endtask

    always @(negedge clk) if (cmp_en) begin
        chk("model_outputs", {8'd0, dut_vec()}, {8'd0, mdl_vec()});
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("model_bubble_cnt", {144'd0, cnt_act},
            {144'd0, (m_bubbles > 65535) ? 16'hFFFF : 16'(m_bubbles)});
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {WB_in, MEM_in, EX_in} = '0;
        valid_in = 1; stall_in = 0; flush_in = 0;
    endtask

    initial begin
        repeat (2) tick();
        chk("reset_state", {8'd0, dut_vec()}, 160'd0);
        chk("reset_cnt", {144'd0, cnt_act}, 160'd0);
        reset_n = 1;
        cmp_en = 1;
        // load latency
        idle();
        WB_in = 2'b10; EX_in = 4'b1100; rd_data1_in = 32'h1234_5678; rd_in = 5'd9;
        tick();
        chk("load_wb", {158'd0, WB_out}, 160'b10);
        chk("load_ex", {156'd0, EX_out}, 160'b1100);
        chk("load_d1", {128'd0, rd_data1_out}, 160'h1234_5678);
        chk("load_rd", {155'd0, rd_out}, 160'd9);
        chk("load_valid", {159'd0, valid_out}, 160'd1);
        // async reset mid-cycle with nonzero outputs
        #1 reset_n = 0;
        #1 chk("async_reset", {8'd0, dut_vec()}, 160'd0);
        tick();
        reset_n = 1;
        // stall holds for three cycles
        idle();
        MEM_in = 2'b10; EX_in = 4'b0001;
        tick();
        stall_in = 1; MEM_in = 2'b01; EX_in = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_mem", {158'd0, MEM_out}, 160'b10);
            chk("stall_ex", {156'd0, EX_out}, 160'b0001);
        end
        stall_in = 0;
        tick();
        chk("release_mem", {158'd0, MEM_out}, 160'b01);
        // flush wins over stall
        stall_in = 1; flush_in = 1; WB_in = 2'b10; valid_in = 1;
        tick();
        chk("flush_prio", {151'd0, WB_out, MEM_out, EX_out, valid_out}, 160'd0);
        // invalid slot
        idle();
        valid_in = 0; MEM_in = 2'b01;
        tick();
        chk("invalid_mem", {158'd0, MEM_out}, 160'd0);
        chk("invalid_valid", {159'd0, valid_out}, 160'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        #1 reset_n = 0;
        tick();
        reset_n = 1;
        idle();
        flush_in = 1;
        repeat (5) tick();
        flush_in = 0; stall_in = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("cnt_stall", {144'd0, cnt_act}, 160'd5);
        end
        stall_in = 0; flush_in = 1;
        repeat (65530) tick();
        chk("cnt_full", {144'd0, cnt_act}, 160'hFFFF);
        tick();
        chk("cnt_sat", {144'd0, cnt_act}, 160'hFFFF);
        flush_in = 0;
`endif
        // random traffic with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            WB_in = 2'($urandom); MEM_in = 2'($urandom); EX_in = 4'($urandom);
            valid_in = ($urandom_range(0, 3) != 0);
            stall_in = ($urandom_range(0, 3) == 0);
            flush_in = ($urandom_range(0, 5) == 0);
            pc_plus4_in = $urandom; rd_data1_in = $urandom;
            rd_data2_in = $urandom; imm_in = $urandom;
            rs_in = 5'($urandom); rt_in = 5'($urandom); rd_in = 5'($urandom);
            reset_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset_n = 1;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
